// File: rtl/cmp_pkg.sv
// Shared types, defaults and the round-robin pick for the shared comparator arbiter.
package cmp_pkg;

  localparam int CMP_W    = 32;
  localparam int CMP_NREQ = 2;
  localparam int MAX_NREQ = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_RESP = 2'd2
  } cmp_state_e;

  typedef struct packed {
    logic is_small;
    logic is_equal;
  } cmp_rsp_t;

  // One-hot grant to the first valid requester, scanning cyclically from last+1.
  function automatic logic [MAX_NREQ-1:0] rr_pick(input logic [MAX_NREQ-1:0] valid,
                                                  input logic [2:0]          last,
                                                  input int                  n);
    logic [MAX_NREQ-1:0] grant;
    logic                found;
    int                  idx;
    grant = '0;
    found = 1'b0;
    for (int i = 1; i <= MAX_NREQ; i++) begin
      idx = (int'(last) + i) % n;
      if ((i <= n) && !found && valid[idx[2:0]]) begin
        grant[idx[2:0]] = 1'b1;
        found           = 1'b1;
      end else begin
        found = found;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/cmp_core.sv
// Combinational W-bit magnitude comparator with selectable signedness.
module cmp_core
  import cmp_pkg::*;
#(
  parameter int W = CMP_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         is_signed,
  output logic         is_small,
  output logic         is_equal
);

  // Differing sign bits in signed mode decide the order by A's sign alone.
  always_comb begin
    is_equal = (a == b);
    if (is_signed && (a[W-1] != b[W-1])) begin
      is_small = a[W-1];
    end else begin
      is_small = (a < b);
    end
  end

endmodule

// File: rtl/cmp_share_arbiter.sv
// Round-robin sharing of one comparator between NREQ requesters with
// valid/ready request and response handshakes.
module cmp_share_arbiter
  import cmp_pkg::*;
#(
  parameter int NREQ = CMP_NREQ,
  parameter int W    = CMP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_signed,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [W-1:0]      rsp_result,
  output logic              rsp_equal,
  output logic              rsp_small,
  output logic              busy
);

  cmp_state_e          state_q, state_d;
  logic [W-1:0]        a_q, b_q;
  logic                sgn_q;
  logic [NREQ-1:0]     owner_q;
  logic [2:0]          owner_idx_q;
  logic [2:0]          last_q;
  logic [NREQ-1:0]     rsp_valid_q;
  cmp_rsp_t            rsp_q;

  logic [MAX_NREQ-1:0] pick_s;
  logic [NREQ-1:0]     grant_s;
  logic [2:0]          gidx_s;
  logic [W-1:0]        sel_a_s, sel_b_s;
  logic                sel_sgn_s;
  logic                accept_s;
  logic                rsp_fire_s;
  logic                core_small_s, core_equal_s;

  // Grant decode and operand mux; one-hot grant lets the mux be a plain AND-OR.
  always_comb begin
    pick_s    = rr_pick(MAX_NREQ'(req_valid), last_q, NREQ);
    grant_s   = pick_s[NREQ-1:0];
    gidx_s    = 3'd0;
    sel_a_s   = '0;
    sel_b_s   = '0;
    sel_sgn_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      gidx_s    = gidx_s | ({3{grant_s[i]}} & 3'(i));
      sel_a_s   = sel_a_s | (req_a[i*W +: W] & {W{grant_s[i]}});
      sel_b_s   = sel_b_s | (req_b[i*W +: W] & {W{grant_s[i]}});
      sel_sgn_s = sel_sgn_s | (req_signed[i] & grant_s[i]);
    end
    accept_s   = (state_q == ST_IDLE) && (|grant_s);
    rsp_fire_s = |(rsp_valid_q & rsp_ready);
  end

  cmp_core #(.W(W)) u_core (
    .a         (a_q),
    .b         (b_q),
    .is_signed (sgn_q),
    .is_small  (core_small_s),
    .is_equal  (core_equal_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) state_d = ST_CMP;
        else          state_d = ST_IDLE;
      end
      ST_CMP:  state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_fire_s) state_d = ST_IDLE;
        else            state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture, response registers and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      sgn_q       <= 1'b0;
      owner_q     <= '0;
      owner_idx_q <= 3'd0;
      last_q      <= 3'(NREQ-1);
      rsp_valid_q <= '0;
      rsp_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            a_q         <= sel_a_s;
            b_q         <= sel_b_s;
            sgn_q       <= sel_sgn_s;
            owner_q     <= grant_s;
            owner_idx_q <= gidx_s;
          end
        end
        ST_CMP: begin
          rsp_q.is_small <= core_small_s;
          rsp_q.is_equal <= core_equal_s;
          rsp_valid_q    <= owner_q;
        end
        ST_RESP: begin
          if (rsp_fire_s) begin
            rsp_valid_q <= '0;
            last_q      <= owner_idx_q;
          end
        end
        default: begin
          rsp_valid_q <= '0;
        end
      endcase
    end
  end

  // Output decode.
  always_comb begin
    req_ready  = (state_q == ST_IDLE) ? grant_s : '0;
    busy       = (state_q != ST_IDLE);
    rsp_valid  = rsp_valid_q;
    rsp_small  = rsp_q.is_small;
    rsp_equal  = rsp_q.is_equal;
    rsp_result = {{(W-1){1'b0}}, rsp_q.is_small};
  end

endmodule

// File: doc/cmp_share_arbiter.md
# cmp_share_arbiter

Shares one 32-bit signed/unsigned magnitude comparator between several requesters, for example the ALU `slt`/`sltu` path and the branch-resolution unit. Each requester uses a valid/ready request handshake and a valid/ready response handshake. A round-robin arbiter grants one requester at a time. A three-state FSM sequences operand capture, compare and response hold. The block sits in the execute stage between the requesting units and a single `cmp_core` instance.

## Interface
Parameters:
- `NREQ`, 2, number of requesters (2..8).
- `W`, 32, operand width.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in NREQ: request valid, one bit per requester.
- `req_ready` out NREQ: request accepted. At most one bit is high at a time.
- `req_a` in NREQ*W: operand A. Requester i uses slice [i*W +: W].
- `req_b` in NREQ*W: operand B, sliced the same way.
- `req_signed` in NREQ: 1 selects two's-complement compare, 0 selects unsigned.
- `rsp_valid` out NREQ: one-hot; marks the owner of the current result.
- `rsp_ready` in NREQ: requester consumes the result.
- `rsp_result` out W: {(W-1)'b0, small}.
- `rsp_equal` out 1: A == B.
- `rsp_small` out 1: A < B under the selected signedness.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- FSM states are IDLE, CMP and RESP. Reset state is IDLE.
- **IDLE**
  - Grant goes to the first requester with `req_valid` set, scanning cyclically from `last+1`.
  - `req_ready[g]` is combinational: (state==IDLE) & grant[g].
  - On a transfer, the block latches A, B, signed and owner g, then moves to CMP.
  - With no valid request, it stays in IDLE.
- **CMP**
  - `cmp_core` evaluates the latched operands.
  - `small`, `equal` and the one-hot owner are registered into the response registers. State moves to RESP.
- **RESP**
  - `rsp_valid[owner]` is held at 1, with result fields stable.
  - When `rsp_ready[owner]` is 1, the block clears `rsp_valid`, sets `last` to owner and returns to IDLE.
  - `rsp_ready` bits of non-owners are ignored.
- **Compare rules**
  - `equal` = (A == B) bitwise, independent of signedness.
  - Unsigned mode: `small` = A < B as unsigned.
  - Signed mode, differing sign bits: `small` = A[W-1].
  - Signed mode, equal sign bits: `small` is the unsigned result.
  - `small` and `equal` are never both 1.
- **Fairness**: `last` resets to NREQ-1, so requester 0 has top priority after reset. Under continuous contention every requester is served within NREQ transactions.
- **Requester obligations**: hold `req_valid`, operands and `req_signed` stable until `req_ready`. Dropping `req_valid` before a grant is legal; that request is simply not served.
- The arbiter never asserts `req_ready` to a requester whose `req_valid` is low.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_result`=0, `rsp_equal`=0, `rsp_small`=0, `busy`=0, state IDLE, `last`=NREQ-1.
- **Latency**: request transfer in cycle t, CMP in t+1, `rsp_valid` high from t+2.
- **Throughput**: with `rsp_ready` tied high, the response handshake completes in t+2 and the next accept is possible in t+3, giving one compare per 3 cycles.
- **Backpressure**: `rsp_valid` and all result fields hold indefinitely while `rsp_ready[owner]` is 0. No `req_ready` is asserted during that time.
- **Request during RESP or CMP**: it waits. It is arbitrated in the first IDLE cycle.
- **Reset mid-operation** (any state): the transaction is abandoned and no response is issued. All outputs return to reset values asynchronously.
- **Operand change after transfer**: no effect, because operands are latched at the handshake.

## Structure
- Package `cmp_pkg` holds:
  - the state enum (IDLE/CMP/RESP);
  - localparam `CMP_W`=32;
  - the default `NREQ`;
  - `cmp_rsp_t` = {small, equal}.
- Sub-module `cmp_core` is purely combinational: inputs `a`, `b`, `is_signed`; outputs `small`, `equal`. It is instantiated once.
- The round-robin pick is a function in the package (`rr_pick`: valid vector and last index to one-hot grant). It is not a separate module.

## Test plan
- **Unsigned compare**: req0 sends A=0x00000005, B=0x00000007, signed=0, at cycle 0. Required: `req_ready[0]`=1 in cycle 0; `rsp_valid`=01 from cycle 2; `rsp_result`=0x00000001; `rsp_equal`=0.
- **Signedness**: req0 sends A=0xFFFFFFFF, B=0x00000001. Required: signed=1 gives `rsp_small`=1; signed=0 gives `rsp_small`=0, `rsp_result`=0.
- **Equality**: A=B=0x80000000, signed=1. Required: `rsp_equal`=1, `rsp_small`=0, `rsp_result`=0.
- **Contention**: req0 and req1 both hold `req_valid`=1 from reset, `rsp_ready`=11. Required: grant order 0,1,0,1; accepts at cycles 0,3,6,9.
- **Backpressure**: response pending, `rsp_ready` held 0 for 4 cycles, req1 valid meanwhile. Required: `rsp_valid`, `rsp_result` and `rsp_equal` are unchanged for all 4 cycles; `req_ready`=00; `busy`=1; req1 is granted in the cycle after the response handshake.
- **Reset mid-op**: assert `rst_n`=0 while the FSM is in CMP. Required: all outputs 0 immediately, no `rsp_valid` after release, and the next simultaneous req0/req1 goes to req0.
